// File: rtl/mul_hilo_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mul_hilo_ctrl_pkg                                                    |
// | Function codes, multiplier Signal codes and FSM encoding shared by   |
// | the HI/LO multiply controller.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mul_hilo_ctrl_pkg;

  localparam int c_DATA_W = 32;

  localparam logic [5:0] c_MULTU = 6'd25;
  localparam logic [5:0] c_MFHI  = 6'd16;
  localparam logic [5:0] c_MTHI  = 6'd17;
  localparam logic [5:0] c_MFLO  = 6'd18;
  localparam logic [5:0] c_MTLO  = 6'd19;

  localparam logic [5:0] c_SIG_MULTU = 6'b011001;
  localparam logic [5:0] c_SIG_OUT   = 6'b111111;
  localparam logic [5:0] c_SIG_IDLE  = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_OUT  = 3'd3,
    ST_CAPT = 3'd4
  } state_e;

  function automatic logic is_hilo_op(input logic [5:0] funct);
    return (funct == c_MULTU) || (funct == c_MFHI) || (funct == c_MTHI) ||
           (funct == c_MFLO)  || (funct == c_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_hilo_ctrl_hilo_regs.sv
// +----------------------------------------------------------------------+
// | hilo_regs                                                            |
// | HI/LO storage: product-capture port, MTHI/MTLO port, read mux.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hilo_regs
  import mul_hilo_ctrl_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  i_cap_en,
  input  logic [2*c_DATA_W-1:0] i_cap_data,
  input  logic                  i_wr_hi,
  input  logic                  i_wr_lo,
  input  logic [c_DATA_W-1:0]   i_wr_data,
  input  logic                  i_rd_hi,
  input  logic                  i_rd_lo,
  output logic [c_DATA_W-1:0]   o_rd_data
);

  logic [c_DATA_W-1:0] r_hi;
  logic [c_DATA_W-1:0] r_lo;

  // Product capture overrides any simultaneous move-to write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cap_en) begin
      r_hi <= i_cap_data[2*c_DATA_W-1:c_DATA_W];
      r_lo <= i_cap_data[c_DATA_W-1:0];
    end else begin
      if (i_wr_hi) r_hi <= i_wr_data;
      if (i_wr_lo) r_lo <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_hi)      o_rd_data = r_hi;
    else if (i_rd_lo) o_rd_data = r_lo;
  end

endmodule

`default_nettype wire

// File: rtl/mul_hilo_ctrl.sv
// +----------------------------------------------------------------------+
// | mul_hilo_ctrl                                                        |
// | Sequences an external shift-add multiplier and owns HI/LO access.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int ITER_CYCLES = 32,
  parameter int FUNCT_W     = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  OpValid,
  input  logic [FUNCT_W-1:0]    OpFunct,
  input  logic [c_DATA_W-1:0]   OpA,
  input  logic [c_DATA_W-1:0]   OpB,
  output logic                  Stall,
  output logic [c_DATA_W-1:0]   RdData,
  output logic                  Busy,
  output logic [FUNCT_W-1:0]    MulSignal,
  output logic [c_DATA_W-1:0]   MulDataA,
  output logic [c_DATA_W-1:0]   MulDataB,
  output logic                  MulReset,
  input  logic [2*c_DATA_W-1:0] MulDataOut
);

  localparam int c_CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ITER_CYCLES - 1);

  state_e               r_state;
  state_e               w_next_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_DATA_W-1:0]  r_data_a;
  logic [c_DATA_W-1:0]  r_data_b;
  logic [FUNCT_W-1:0]   w_sig;

  logic w_idle;
  logic w_known;
  logic w_accept;
  logic w_mul_go;
  logic w_rd_hi;
  logic w_rd_lo;
  logic w_wr_hi;
  logic w_wr_lo;
  logic w_capture;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_known   = OpValid & is_hilo_op(6'(OpFunct));
  assign w_accept  = w_known & w_idle;
  assign w_mul_go  = w_accept & (OpFunct == FUNCT_W'(c_MULTU));
  assign w_rd_hi   = w_accept & (OpFunct == FUNCT_W'(c_MFHI));
  assign w_rd_lo   = w_accept & (OpFunct == FUNCT_W'(c_MFLO));
  assign w_wr_hi   = w_accept & (OpFunct == FUNCT_W'(c_MTHI));
  assign w_wr_lo   = w_accept & (OpFunct == FUNCT_W'(c_MTLO));
  assign w_capture = (r_state == ST_CAPT);

  assign Stall     = w_known & ~w_idle;
  assign Busy      = ~w_idle;
  assign MulSignal = w_sig;
  assign MulDataA  = r_data_a;
  assign MulDataB  = r_data_b;
  assign MulReset  = Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_LOAD)      r_cnt <= '0;
      else if (r_state == ST_ITER) r_cnt <= r_cnt + 1'b1;
      // Operands stay on the multiplier inputs until the next accepted multiply.
      if (w_mul_go) begin
        r_data_a <= OpA;
        r_data_b <= OpB;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sig        = FUNCT_W'(c_SIG_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_mul_go) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_sig        = FUNCT_W'(c_SIG_MULTU);
        w_next_state = ST_ITER;
      end
      ST_ITER: begin
        w_sig = FUNCT_W'(c_SIG_MULTU);
        if (r_cnt == c_LAST) w_next_state = ST_OUT;
      end
      ST_OUT: begin
        w_sig        = FUNCT_W'(c_SIG_OUT);
        w_next_state = ST_CAPT;
      end
      ST_CAPT: begin
        // Product was registered onto DataOut at the end of OUT.
        w_sig        = FUNCT_W'(c_SIG_OUT);
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  hilo_regs u_hilo_regs (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_cap_en   (w_capture),
    .i_cap_data (MulDataOut),
    .i_wr_hi    (w_wr_hi),
    .i_wr_lo    (w_wr_lo),
    .i_wr_data  (OpA),
    .i_rd_hi    (w_rd_hi),
    .i_rd_lo    (w_rd_lo),
    .o_rd_data  (RdData)
  );

endmodule

`default_nettype wire

// File: tb/tb_mul_hilo_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_mul_hilo_ctrl                                                     |
// | Self-checking bench with a behavioural multiplier and HI/LO model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mul_hilo_ctrl;

  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] S_MULTU = 6'b011001;
  localparam logic [5:0] S_OUT   = 6'b111111;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        OpValid;
  logic [5:0]  OpFunct;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Stall;
  logic [31:0] RdData;
  logic        Busy;
  logic [5:0]  MulSignal;
  logic [31:0] MulDataA;
  logic [31:0] MulDataB;
  logic        MulReset;
  logic [63:0] MulDataOut;

  always #5 Clk = ~Clk;

  mul_hilo_ctrl #(.ITER_CYCLES(32), .FUNCT_W(6)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .OpValid    (OpValid),
    .OpFunct    (OpFunct),
    .OpA        (OpA),
    .OpB        (OpB),
    .Stall      (Stall),
    .RdData     (RdData),
    .Busy       (Busy),
    .MulSignal  (MulSignal),
    .MulDataA   (MulDataA),
    .MulDataB   (MulDataB),
    .MulReset   (MulReset),
    .MulDataOut (MulDataOut)
  );

  // Shift-add multiplier: first MULTU cycle loads, each later one iterates.
  logic [63:0] m_prod;
  logic [63:0] m_mcand;
  logic [31:0] m_mplier;
  logic [5:0]  m_prev;

  always @(posedge Clk) begin
    if (MulReset) begin
      m_prod     <= '0;
      m_mcand    <= '0;
      m_mplier   <= '0;
      m_prev     <= '0;
      MulDataOut <= '0;
    end else begin
      m_prev <= MulSignal;
      if (MulSignal == S_MULTU) begin
        if (m_prev != S_MULTU) begin
          m_mcand  <= {32'd0, MulDataA};
          m_mplier <= MulDataB;
          m_prod   <= '0;
        end else begin
          if (m_mplier[0]) m_prod <= m_prod + m_mcand;
          m_mcand  <= m_mcand << 1;
          m_mplier <= m_mplier >> 1;
        end
      end else if (MulSignal == S_OUT) begin
        MulDataOut <= m_prod;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: cycle number, when the current multiply started/ends.
  int          n      = 0;
  int          acc_at = -1000;
  int          idle_at = 0;
  logic [31:0] hi = '0;
  logic [31:0] lo = '0;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic [63:0] pend = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  function automatic logic known(input logic [5:0] f);
    return f == F_MULTU || f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO;
  endfunction

  task automatic cyc(input logic v, input logic [5:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic rst, output logic stalled);
    logic        busy;
    int          k;
    logic [31:0] exp_rd;
    logic [5:0]  exp_sig;
    Reset   = rst;
    OpValid = v;
    OpFunct = f;
    OpA     = a;
    OpB     = b;
    busy    = (n < idle_at);
    k       = n - acc_at;
    stalled = v && known(f) && busy;
    exp_rd  = '0;
    if (!busy && v && f == F_MFHI) exp_rd = hi;
    if (!busy && v && f == F_MFLO) exp_rd = lo;
    exp_sig = !busy ? 6'd0 : (k <= 33 ? S_MULTU : S_OUT);
    @(negedge Clk);
    if (!rst) begin
      chk("busy",   {63'd0, Busy},      {63'd0, busy});
      chk("stall",  {63'd0, Stall},     {63'd0, stalled});
      chk("rddata", {32'd0, RdData},    {32'd0, exp_rd});
      chk("signal", {58'd0, MulSignal}, {58'd0, exp_sig});
      chk("dataa",  {32'd0, MulDataA},  {32'd0, da});
      chk("datab",  {32'd0, MulDataB},  {32'd0, db});
    end
    chk("mulreset", {63'd0, MulReset}, {63'd0, rst});
    @(posedge Clk);
    if (rst) begin
      hi = '0; lo = '0; da = '0; db = '0;
      idle_at = n + 1;
      acc_at  = -1000;
    end else begin
      if (busy && k == 35) begin
        hi = pend[63:32];
        lo = pend[31:0];
      end
      if (!busy && v) begin
        case (f)
          F_MULTU: begin
            acc_at  = n;
            idle_at = n + 36;
            pend    = {32'd0, a} * {32'd0, b};
            da      = a;
            db      = b;
          end
          F_MTHI: hi = a;
          F_MTLO: lo = a;
          default: ;
        endcase
      end
    end
    n++;
    #1;
  endtask

  task automatic idle(input int cnt);
    logic s;
    for (int i = 0; i < cnt; i++) cyc(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, s);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic s;
    int   tries;
    s     = 1'b1;
    tries = 0;
    while (s && tries < 100) begin
      cyc(1'b1, f, a, b, 1'b0, s);
      tries++;
    end
    checks++;
    assert (!s)
    else begin
      failures++;
      $error("FAIL accept_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic do_reset(input int cnt);
    logic s;
    for (int i = 0; i < cnt; i++) cyc(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, s);
  endtask

  initial begin
    logic        s;
    logic        hold;
    logic        v;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    // Reset, then 3 x 5
    do_reset(2);
    idle(1);
    issue(F_MULTU, 32'd3, 32'd5);
    idle(35);
    issue(F_MFLO, 32'd0, 32'd0);
    issue(F_MFHI, 32'd0, 32'd0);

    // Largest operands
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(35);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);

    // Read held against a multiply in flight
    issue(F_MULTU, 32'd7, 32'd9);
    issue(F_MFLO, 32'd0, 32'd0);

    // Reset in the middle of ITER
    issue(F_MULTU, 32'd1234, 32'd5678);
    idle(11);
    cyc(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, s);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);
    issue(F_MULTU, 32'd2, 32'd2);
    idle(35);
    issue(F_MFLO, 32'd0, 32'd0);

    // Move-to writes, then a zero product overwrites both halves
    issue(F_MTHI, 32'hDEAD_BEEF, 32'd0);
    issue(F_MTLO, 32'h1234_5678, 32'd0);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);
    issue(F_MULTU, 32'd0, 32'd123);
    idle(35);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);

    // Back-to-back multiplies with the second held by Stall
    issue(F_MULTU, 32'd4, 32'd5);
    issue(F_MULTU, 32'd6, 32'd7);
    issue(F_MFLO, 32'd0, 32'd0);

    // Random traffic; a stalled op is held unchanged as the pipeline would
    hold = 1'b0;
    v = 1'b0; f = '0; a = '0; b = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 7);
        case (sel)
          0, 1:    f = F_MULTU;
          2:       f = F_MFHI;
          3:       f = F_MFLO;
          4:       f = F_MTHI;
          5:       f = F_MTLO;
          default: f = 6'($urandom_range(0, 15));
        endcase
        a = $urandom;
        b = $urandom;
      end
      cyc(v, f, a, b, ($urandom_range(0, 249) == 0), s);
      hold = s;
    end
    idle(40);
    issue(F_MFHI, 32'd0, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
